// File: rtl/lfsr_word_ctrl.sv
// lfsr_word_ctrl: drives a bit-serial LFSR, packs its output bit LSB-first
// into WordWidth-bit words and streams a requested number of words out over
// a valid/ready handshake, finishing with a one-cycle done pulse.
module lfsr_word_ctrl #(
    parameter int WordWidth  = 8,
    parameter int CountWidth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CountWidth-1:0] num_words_i,
    output logic                  lfsr_en_o,
    input  logic                  lfsr_rnd_i,
    output logic [WordWidth-1:0]  data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int BitW = (WordWidth > 2) ? $clog2(WordWidth) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [WordWidth-1:0]  shreg_q, shreg_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CountWidth-1:0] words_left_q, words_left_d;
    logic [WordWidth-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Next-state logic: sequencing, bit packing and word counting.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        words_left_d = words_left_q;
        data_d       = data_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (num_words_i != '0) begin
                        words_left_d = num_words_i;
                        bit_cnt_d    = '0;
                        shreg_d      = '0;
                        state_d      = ST_FILL;
                    end else begin
                        // Empty request: report completion without touching the LFSR.
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FILL: begin
                // New bits enter at the top so the first sampled bit ends in bit 0.
                shreg_d   = {lfsr_rnd_i, shreg_q[WordWidth-1:1]};
                bit_cnt_d = bit_cnt_q + BitW'(1);
                if (bit_cnt_q == BitW'(WordWidth - 1)) begin
                    data_d    = shreg_d;
                    bit_cnt_d = '0;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (ready_i) begin
                    words_left_d = words_left_q - CountWidth'(1);
                    bit_cnt_d    = '0;
                    state_d      = (words_left_q == CountWidth'(1)) ? ST_DONE : ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered versions of the state being entered.
        valid_d = (state_d == ST_OUT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers; reset clears everything so no stale word survives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            words_left_q <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            words_left_q <= words_left_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // The LFSR steps only while bits are being collected.
    assign lfsr_en_o = (state_q == ST_FILL);
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_lfsr_word_ctrl.sv
// Bench for lfsr_word_ctrl paired with a 5-bit LFSR (seed 1, feedback q0 XNOR q2).
module tb_lfsr_word_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num = '0;
    logic          lfsr_en;
    logic          lfsr_rnd;
    logic [W-1:0]  data;
    logic          valid;
    logic          ready = 1'b0;
    logic          busy;
    logic          done;

    logic          lfsr_rst = 1'b1;
    logic [4:0]    lq;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    lfsr_word_ctrl #(.WordWidth(W), .CountWidth(CW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .num_words_i(num),
        .lfsr_en_o  (lfsr_en),
        .lfsr_rnd_i (lfsr_rnd),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .busy_o     (busy),
        .done_o     (done)
    );

    // Companion LFSR
    always @(posedge clk) begin
        if (lfsr_rst) lq <= 5'd1;
        else if (lfsr_en) lq <= {lq[0] ~^ lq[2], lq[4:1]};
    end
    assign lfsr_rnd = lq[0];

    // Word built from the LFSR output stream, bits first..first+W-1, LSB first.
    function automatic logic [W-1:0] word_at(input int first);
        logic [4:0]   s;
        logic [W-1:0] w;
        s = 5'd1;
        w = '0;
        for (int i = 0; i < first; i++) s = {s[0] ~^ s[2], s[4:1]};
        for (int b = 0; b < W; b++) begin
            w[b] = s[0];
            s = {s[0] ~^ s[2], s[4:1]};
        end
        return w;
    endfunction

    // Reference model: remaining enable cycles, pending word, remaining words.
    int         m_fill_left = 0;
    bit         m_valid = 1'b0;
    int         m_words = 0;
    bit         m_done = 1'b0;
    logic [W-1:0] m_data = '0;
    int         m_steps = 0;

    always @(posedge clk) begin
        if (lfsr_rst) m_steps <= 0;
        else if (m_fill_left > 0) m_steps <= m_steps + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fill_left <= 0;
            m_valid     <= 1'b0;
            m_words     <= 0;
            m_done      <= 1'b0;
            m_data      <= '0;
        end else if (m_fill_left > 0) begin
            m_fill_left <= m_fill_left - 1;
            if (m_fill_left == 1) begin
                m_valid <= 1'b1;
                m_data  <= word_at(m_steps + 1 - W);
            end
        end else if (m_valid) begin
            if (ready) begin
                m_valid <= 1'b0;
                m_words <= m_words - 1;
                if (m_words == 1) m_done <= 1'b1;
                else m_fill_left <= W;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (start) begin
            if (num == '0) m_done <= 1'b1;
            else begin
                m_words     <= int'(num);
                m_fill_left <= W;
            end
        end
    end

    // Transaction log and event bookkeeping
    int         cyc = 0;
    int         last_acc = 0;
    int         done_cyc = 0;
    int         done_cnt = 0;
    int         en_cnt = 0;
    logic [W-1:0] acc_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid && ready) begin
            acc_q.push_back(data);
            last_acc <= cyc;
            $display("t=%0t word accepted: %h", $time, data);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (lfsr_en) en_cnt <= en_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("m_en", 32'(lfsr_en), 32'(m_fill_left > 0));
                chk("m_valid", 32'(valid), 32'(m_valid));
                chk("m_busy", 32'(busy), 32'((m_fill_left > 0) || m_valid || m_done));
                chk("m_done", 32'(done), 32'(m_done));
                chk("m_data", 32'(data), 32'(m_data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input bit want_done, input int bound, input string nm);
        int n;
        n = 0;
        forever begin
            tick();
            n++;
            if ((!want_done && valid) || (want_done && done)) begin
                checks++;
                break;
            end
            if (n >= bound) begin
                checks++;
                errors++;
                $display("FAIL %s: timeout after %0d cycles, expected event", nm, n);
                break;
            end
        end
    endtask

    task automatic reset_lfsr();
        lfsr_rst = 1'b1;
        tick();
        lfsr_rst = 1'b0;
    endtask

    // Start a burst and count edges (start edge included) until valid_o is seen.
    task automatic start_measure(input logic [CW-1:0] n, output int lat);
        start = 1'b1;
        num   = n;
        lat   = 0;
        repeat (40) begin
            tick();
            lat++;
            start = 1'b0;
            if (valid) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int base, dbase, ebase, lat;
        logic [4:0] snap;

        // Model pins
        chk("pin_word0", 32'(word_at(0)), 32'h0000_00C1);
        chk("pin_word1", 32'(word_at(8)), 32'h0000_0089);

        repeat (3) tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_en", 32'(lfsr_en), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        rst_n = 1'b1;
        lfsr_rst = 1'b0;
        check_en = 1'b1;
        tick();

        // 1: two words with ready held high
        base = acc_q.size(); ebase = en_cnt; dbase = done_cnt;
        ready = 1'b1;
        start = 1'b1; num = 4'd2;
        tick();
        start = 1'b0;
        wait_for(1'b1, 60, "t1_done");
        tick();
        chk("t1_nwords", 32'(acc_q.size() - base), 32'd2);
        if (acc_q.size() >= base + 2) begin
            chk("t1_w0", 32'(acc_q[base]), 32'h0000_00C1);
            chk("t1_w1", 32'(acc_q[base+1]), 32'h0000_0089);
        end
        chk("t1_en_cycles", 32'(en_cnt - ebase), 32'd16);
        chk("t1_done_cnt", 32'(done_cnt - dbase), 32'd1);
        chk("t1_done_lag", 32'(done_cyc - last_acc), 32'd1);

        // 2: stall for 3 cycles on the first word
        reset_lfsr();
        base = acc_q.size();
        ready = 1'b0;
        start = 1'b1; num = 4'd2;
        tick();
        start = 1'b0;
        wait_for(1'b0, 30, "t2_valid");
        snap = lq;
        repeat (3) begin
            chk("t2_hold_data", 32'(data), 32'h0000_00C1);
            chk("t2_hold_en", 32'(lfsr_en), 32'd0);
            tick();
        end
        chk("t2_lfsr_state", 32'(lq), 32'(snap));
        ready = 1'b1;
        wait_for(1'b1, 40, "t2_done");
        tick();
        if (acc_q.size() >= base + 2) begin
            chk("t2_w0", 32'(acc_q[base]), 32'h0000_00C1);
            chk("t2_w1", 32'(acc_q[base+1]), 32'h0000_0089);
        end else chk("t2_nwords", 32'(acc_q.size() - base), 32'd2);

        // 3: zero-word request
        ebase = en_cnt; dbase = done_cnt;
        start = 1'b1; num = 4'd0;
        tick();
        start = 1'b0;
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_done", 32'(done), 32'd1);
        tick();
        chk("t3_busy_after", 32'(busy), 32'd0);
        chk("t3_done_after", 32'(done), 32'd0);
        tick();
        chk("t3_en_cycles", 32'(en_cnt - ebase), 32'd0);
        chk("t3_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // 4: start pulses during FILL and OUT are ignored
        reset_lfsr();
        base = acc_q.size(); dbase = done_cnt; ebase = en_cnt;
        ready = 1'b0;
        start = 1'b1; num = 4'd3;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; num = 4'd5;
        tick();
        start = 1'b0;
        wait_for(1'b0, 30, "t4_valid");
        start = 1'b1; num = 4'd7;
        tick();
        start = 1'b0;
        ready = 1'b1;
        wait_for(1'b1, 60, "t4_done");
        repeat (4) tick();
        chk("t4_nwords", 32'(acc_q.size() - base), 32'd3);
        chk("t4_done_cnt", 32'(done_cnt - dbase), 32'd1);
        chk("t4_en_cycles", 32'(en_cnt - ebase), 32'd24);
        chk("t4_idle_busy", 32'(busy), 32'd0);

        // 5: asynchronous reset in the middle of word 1
        reset_lfsr();
        base = acc_q.size();
        ready = 1'b1;
        start = 1'b1; num = 4'd2;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_en", 32'(lfsr_en), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(valid), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_data", 32'(data), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        reset_lfsr();
        chk("t5_no_partial", 32'(acc_q.size() - base), 32'd0);
        start = 1'b1; num = 4'd1;
        tick();
        start = 1'b0;
        wait_for(1'b1, 40, "t5_done");
        tick();
        if (acc_q.size() >= base + 1) chk("t5_w0", 32'(acc_q[base]), 32'h0000_00C1);
        else chk("t5_nwords", 32'(acc_q.size() - base), 32'd1);

        // 6: back-to-back single-word bursts
        reset_lfsr();
        base = acc_q.size(); dbase = done_cnt;
        ready = 1'b1;
        start_measure(4'd1, lat);
        chk("t6_lat0", 32'(lat), 32'd9);
        wait_for(1'b1, 20, "t6_done0");
        tick();
        start_measure(4'd1, lat);
        chk("t6_lat1", 32'(lat), 32'd9);
        wait_for(1'b1, 20, "t6_done1");
        tick();
        if (acc_q.size() >= base + 2) begin
            chk("t6_w0", 32'(acc_q[base]), 32'h0000_00C1);
            chk("t6_w1", 32'(acc_q[base+1]), 32'h0000_0089);
        end else chk("t6_nwords", 32'(acc_q.size() - base), 32'd2);
        chk("t6_done_cnt", 32'(done_cnt - dbase), 32'd2);

        repeat (2) tick();
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_word_ctrl.md
# lfsr_word_ctrl

Sequencer for the team's bit-serial lfsr block. On a start request it drives the LFSR enable and packs the serial random bit into WordWidth-bit words. It delivers a programmed number of words over a valid/ready stream, then pulses done. It sits between the LFSR datapath and any consumer that wants parallel random words, such as test-pattern or noise injection.

## Interface
- WordWidth, 8: bits per output word (>=2).
- CountWidth, 4: width of the word-count request.

- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  start request, sampled in IDLE only.
- num_words_i  in  CountWidth  words to produce, sampled with start_i.
- lfsr_en_o  out  1  enable to the LFSR; it advances one step per cycle high.
- lfsr_rnd_i  in  1  current LFSR output bit (state bit 0, before the step).
- data_o  out  WordWidth  packed word.
- valid_o  out  1  data_o valid.
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse after the last word is accepted.

## Operation
- **States:** IDLE, FILL, OUT, DONE. All outputs are registered except lfsr_en_o, which decodes FILL.
- **IDLE:**
  - start_i=1 and num_words_i!=0: latch the count into words_left, clear bit_cnt and the shift register, go to FILL.
  - start_i=1 and num_words_i==0: go to DONE; the LFSR is never enabled.
  - start_i=0: stay.
- **FILL:**
  - lfsr_en_o=1.
  - Each cycle: shreg <= {lfsr_rnd_i, shreg[WordWidth-1:1]} and bit_cnt++.
  - The first sampled bit lands in data bit 0 (LSB-first).
  - When bit_cnt==WordWidth-1, go to OUT and load data_o from the updated shift value.
- **OUT:**
  - valid_o=1, lfsr_en_o=0, so the LFSR holds its state.
  - data_o is stable until accepted.
  - On valid_o && ready_i: decrement words_left. Go to DONE if words_left was 1, else back to FILL with bit_cnt=0.
- **DONE:** done_o=1 for exactly one cycle, then IDLE.
- **start_i:** ignored outside IDLE, including in DONE.
- **ready_i:** ignored when valid_o=0.
- **Count range:** word count is 1..2^CountWidth-1. words_left is CountWidth bits and never wraps below 1 before exit.
- **Reset (rst_ni=0, asynchronous, any time including mid-word or mid-handshake):**
  - State goes to IDLE; shreg, bit_cnt and words_left clear.
  - data_o=0, valid_o=0, busy_o=0, done_o=0, lfsr_en_o=0, all immediately.
  - No partial word is ever presented after reset.

## Timing
- Cycle numbering: start_i is sampled at edge E0.
  - Cycles E0..E0+WordWidth-1 after the edge: FILL, lfsr_en_o high for exactly WordWidth cycles.
  - valid_o rises after edge E0+WordWidth, i.e. first-word latency is WordWidth+1 cycles from the start edge.
- With ready_i held high: each word costs WordWidth FILL cycles plus 1 OUT cycle.
  - An N-word burst runs N*(WordWidth+1) cycles from E0 to DONE entry.
  - done_o follows one cycle after the last accept.
- Back-to-back starts: a start in the cycle after done_o is accepted (the FSM is in IDLE then).
- Total LFSR steps per burst: exactly N*WordWidth. None occur in OUT, DONE or IDLE.

## Test plan
All scenarios pair the block with the team's 5-bit lfsr (reset state 5'd1, feedback q0 XNOR q2). WordWidth=8, CountWidth=4.
1. Reset, then start_i=1 with num_words_i=2, ready_i=1 -> words 8'hC1 then 8'h89, done_o one cycle after the second accept, lfsr_en_o high for exactly 16 cycles total.
2. Same as 1, but ready_i low for 3 cycles after the first valid_o -> data_o holds 8'hC1, lfsr_en_o=0, and the LFSR state is unchanged through the stall. Second word is still 8'h89.
3. start_i=1 with num_words_i=0 -> busy_o high for 1 cycle, done_o pulses, valid_o and lfsr_en_o never assert.
4. start_i pulsed again during FILL and OUT of a 3-word burst -> ignored; exactly 3 words and 1 done_o.
5. rst_ni low for 1 cycle at bit 4 of word 1 -> all outputs 0 asynchronously. A new start (after also resetting the LFSR) yields 8'hC1 again.
6. Two back-to-back bursts of 1 word each, second start asserted the cycle after done_o -> words 8'hC1 then 8'h89, two done_o pulses, start-to-valid latency of 9 cycles each.
